// File: rtl/spis_bus_pkg.sv
// Shared definitions for the SPIS CPU bus UART transmitter.
// Contents: bus widths, register offsets inside the 4-byte window,
// STATUS bit positions and the transmitter FSM state type.
// Build option: SPIS_UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package spis_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  // Register offsets, addressBus[1:0]
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIVLO  = 2'd2;
  localparam logic [1:0] OFF_DIVHI  = 2'd3;

  // STATUS bit positions; bits 7:4 read as zero
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

`ifdef SPIS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } uart_state_e;
`endif

endpackage

// File: rtl/spis_sync_fifo.sv
// Synchronous FIFO, DATA_W x DEPTH, first-word-fall-through read.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties FIFO)
//   push, push_data   write one entry at the rising edge
//   pop               discard the head entry at the rising edge
//   pop_data          current head entry (valid while !empty)
//   full, empty       occupancy flags
// The caller never pushes while full unless it pops in the same cycle, and
// never pops while empty. Pointers carry one extra bit so full and empty are
// distinguishable when the index bits match.
module spis_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  // A push into the slot being popped in the same cycle is safe because
  // pop_data is taken combinationally before the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/spis_uart_tx.sv
// Memory-mapped UART transmitter on the SPIS CPU bus.
// Decodes a 4-byte window at BASE_ADDR (TXDATA, STATUS, DIVLO, DIVHI), queues
// written bytes in a TX FIFO and sends them on txd, LSB first, idle high.
// Each bit lasts (divisor + 1) clocks; the divisor is latched per frame.
// Ports:
//   clock, resetN  system clock (rising edge), asynchronous active-low reset
//   dataBus        shared bidirectional data bus, driven only on decoded reads
//   addressBus     CPU address
//   write          1 = CPU write cycle, dataBus carries write data
//   sync           1 = opcode fetch, never decoded
//   txd            registered serial output
//   txIdle         registered: FIFO empty and FSM idle
//   dbg_state      current transmitter FSM state (observation only)
// Build option: define SPIS_UART_TX_PARITY_EN for 8E1 frames (even parity
// bit after the data bits); undefined gives 8N1. Register map is unchanged.
//
// Bus handshake: there is no ready/wait. A cycle is ours when hit is true.
// Reads are combinational (dataBus driven while hit && !write); writes are
// captured at the rising edge while hit && write. TXDATA writes that find the
// FIFO full (and no pop in the same cycle) are dropped and set overflow.
module spis_uart_tx
  import spis_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'hFF0,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [15:0]       DEFAULT_DIV = 16'd103
) (
  input  logic              clock,
  input  logic              resetN,
  inout  wire  [DATA_W-1:0] dataBus,
  input  logic [ADDR_W-1:0] addressBus,
  input  logic              write,
  input  logic              sync,
  output logic              txd,
  output logic              txIdle,
  output uart_state_e       dbg_state
);

  // ---------------- decode and registers ----------------
  logic              hit;
  logic [1:0]        off;
  logic              wr_txdata;
  logic [DATA_W-1:0] rdata;
  logic [15:0]       div_q;
  logic              ovf;

  // FIFO interface
  logic              f_push;
  logic              f_pop;
  logic [DATA_W-1:0] f_dout;
  logic              f_full;
  logic              f_empty;

  assign hit       = (addressBus[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]) && !sync;
  assign off       = addressBus[1:0];
  assign wr_txdata = hit && write && (off == OFF_TXDATA);
  // A full FIFO still accepts the byte when the FSM frees a slot this cycle.
  assign f_push    = wr_txdata && (!f_full || f_pop);

  // ---------------- transmitter FSM ----------------
  uart_state_e state;
  uart_state_e state_n;
  logic [15:0] bit_div;
  logic [15:0] cnt;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        bit_done;
  logic        load;
  logic        txd_n;
`ifdef SPIS_UART_TX_PARITY_EN
  logic        par_q;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_STATUS: begin
        rdata[STAT_FULL]  = f_full;
        rdata[STAT_EMPTY] = f_empty;
        rdata[STAT_BUSY]  = (state != ST_IDLE);
        rdata[STAT_OVF]   = ovf;
      end
      OFF_DIVLO: rdata = div_q[7:0];
      OFF_DIVHI: rdata = div_q[15:8];
      default:   rdata = '0;
    endcase
  end

  assign dataBus = (hit && !write) ? rdata : {DATA_W{1'bz}};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      div_q <= DEFAULT_DIV;
      ovf   <= 1'b0;
    end else if (hit && write) begin
      case (off)
        OFF_TXDATA: if (!f_push) ovf <= 1'b1;
        OFF_STATUS: ovf <= 1'b0;
        OFF_DIVLO:  div_q[7:0]  <= dataBus;
        OFF_DIVHI:  div_q[15:8] <= dataBus;
        default:    ;
      endcase
    end
  end

  spis_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (resetN),
    .push      (f_push),
    .push_data (dataBus),
    .pop       (f_pop),
    .pop_data  (f_dout),
    .full      (f_full),
    .empty     (f_empty)
  );

  assign bit_done  = (cnt == bit_div);
  assign dbg_state = state;

  // txd_n is the level txd takes after the coming edge, so txd itself is a
  // plain flop and never glitches.
  always_comb begin
    state_n = state;
    txd_n   = 1'b1;
    f_pop   = 1'b0;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!f_empty) begin
          f_pop   = 1'b1;
          load    = 1'b1;
          state_n = ST_START;
          txd_n   = 1'b0;
        end
      end
      ST_START: begin
        txd_n = 1'b0;
        if (bit_done) begin
          state_n = ST_DATA;
          txd_n   = shreg[0];
        end
      end
      ST_DATA: begin
        txd_n = shreg[0];
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef SPIS_UART_TX_PARITY_EN
            state_n = ST_PARITY;
            txd_n   = par_q;
`else
            state_n = ST_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            txd_n = shreg[1];
          end
        end
      end
`ifdef SPIS_UART_TX_PARITY_EN
      ST_PARITY: begin
        txd_n = par_q;
        if (bit_done) begin
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        txd_n = 1'b1;
        if (bit_done) begin
          if (!f_empty) begin
            // back-to-back frame: start bit follows the stop bit directly
            f_pop   = 1'b1;
            load    = 1'b1;
            state_n = ST_START;
            txd_n   = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= ST_IDLE;
      txd     <= 1'b1;
      txIdle  <= 1'b1;
      bit_div <= '0;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef SPIS_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      txd   <= txd_n;
      // Next-state idle and nothing entering the FIFO means the FIFO will be
      // empty too: an idle next state is only reached with an empty FIFO.
      txIdle <= (state_n == ST_IDLE) && !f_push;
      if (load) begin
        bit_div <= div_q;
        shreg   <= f_dout;
        bit_idx <= '0;
        cnt     <= '0;
`ifdef SPIS_UART_TX_PARITY_EN
        par_q   <= ^f_dout;
`endif
      end else if (state != ST_IDLE) begin
        if (bit_done) begin
          cnt <= '0;
          if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule
